// File: rtl/action_pkg.sv
// Shared definitions for the player action conditioner: action bit indices,
// per-button FSM state type and a small constant helper.
package action_pkg;

  localparam int ACT_RIGHT = 0;
  localparam int ACT_LEFT  = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FIRST  = 3'd1,
    ST_DELAY  = 3'd2,
    ST_REPEAT = 3'd3,
    ST_HELD   = 3'd4
  } act_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus debounce counter for one button; reports the
// debounced level and a one-cycle pulse coinciding with an accepted rise.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_button_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_differ;
  logic          w_accept;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
  end

  assign w_differ = (r_sync2 != r_level);
  // The change is accepted on the cycle that completes the run of disagreement.
  assign w_accept = w_differ && (r_cnt == LAST_COUNT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_button_raw;
      r_sync2 <= r_sync1;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else if (r_cnt < LAST_COUNT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_accept && r_sync2;

endmodule

// File: rtl/action_conditioner.sv
// Turns debounced buttons into one-cycle move pulses aligned to the vsync
// frame tick. Define ACTION_AUTOREPEAT_EN to enable DAS/ARR auto-repeat.
module action_conditioner
  import action_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DAS_FRAMES      = 16,
  parameter int ARR_FRAMES      = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] buttons_raw,
  input  logic       vsync,
  output logic [1:0] actions
);

  logic       r_vsync;
  logic [1:0] r_pending;
  logic [1:0] r_actions;
  logic       w_tick;
  logic [1:0] w_level;
  logic [1:0] w_rise;
  logic [1:0] w_req;
  logic [1:0] w_issue;
  logic       w_cancel;

  if (DAS_FRAMES < 1 || ARR_FRAMES < 1) begin : g_bad_frame_counts
  end

  assign w_tick = vsync && !r_vsync;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_btn
    act_state_e r_state;
    logic       w_active;

    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_button_raw(buttons_raw[gi]),
      .o_level     (w_level[gi]),
      .o_rise      (w_rise[gi])
    );

    // Still held and not being re-armed by a fresh press this cycle.
    assign w_active = (r_state != ST_IDLE) && w_level[gi] && !w_rise[gi];

`ifdef ACTION_AUTOREPEAT_EN
    localparam int FCW = $clog2(max_int(DAS_FRAMES, ARR_FRAMES) + 1);

    logic [FCW-1:0] r_fcnt;
    logic [FCW-1:0] w_fcnt_inc;
    logic           w_das_hit;
    logic           w_arr_hit;

    assign w_fcnt_inc = (r_fcnt == {FCW{1'b1}}) ? r_fcnt : r_fcnt + 1'b1;
    assign w_das_hit  = w_tick && w_active && (r_state == ST_DELAY) &&
                        (w_fcnt_inc == FCW'(DAS_FRAMES));
    assign w_arr_hit  = w_tick && w_active && (r_state == ST_REPEAT) &&
                        (w_fcnt_inc == FCW'(ARR_FRAMES));
    // Repeat requests raised on a tick are issued on that same tick.
    assign w_req[gi]  = w_das_hit || w_arr_hit;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= ST_IDLE;
        r_fcnt  <= '0;
      end else if (w_rise[gi]) begin
        r_state <= ST_FIRST;
        r_fcnt  <= '0;
      end else if ((r_state != ST_IDLE) && !w_level[gi]) begin
        r_state <= ST_IDLE;
        r_fcnt  <= '0;
      end else if (w_tick) begin
        case (r_state)
          ST_FIRST: begin
            r_state <= ST_DELAY;
            r_fcnt  <= '0;
          end
          ST_DELAY: begin
            if (w_das_hit) begin
              r_state <= ST_REPEAT;
              r_fcnt  <= '0;
            end else begin
              r_fcnt <= w_fcnt_inc;
            end
          end
          ST_REPEAT: begin
            r_fcnt <= w_arr_hit ? '0 : w_fcnt_inc;
          end
          default: r_state <= r_state;
        endcase
      end
    end
`else
    assign w_req[gi] = 1'b0;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= ST_IDLE;
      end else if (w_rise[gi]) begin
        r_state <= ST_FIRST;
      end else if ((r_state != ST_IDLE) && !w_level[gi]) begin
        r_state <= ST_IDLE;
      end else if (w_tick && (r_state == ST_FIRST)) begin
        r_state <= ST_HELD;
      end
    end
`endif
  end

  assign w_issue  = r_pending | w_req;
  assign w_cancel = w_issue[ACT_RIGHT] && w_issue[ACT_LEFT];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vsync   <= 1'b0;
      r_pending <= 2'b00;
      r_actions <= 2'b00;
    end else begin
      r_vsync <= vsync;
      if (w_tick) begin
        r_actions <= w_cancel ? 2'b00 : w_issue;
      end else begin
        r_actions <= 2'b00;
      end
      // A press accepted on a tick waits for the following tick.
      r_pending <= (w_tick ? 2'b00 : r_pending) | w_rise;
    end
  end

  assign actions = r_actions;

endmodule

// File: tb/tb_action_conditioner.sv
// Scoreboard bench for action_conditioner: a frame-level reference model
// predicts the action word of every tick; a monitor checks the DUT output.
`timescale 1ns/1ps
module tb_action_conditioner;

  localparam int D    = 4;
  localparam int DAS  = 3;
  localparam int ARR  = 2;
  localparam int VPER = 50;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] buttons_raw = 2'b11;
  logic       vsync = 1'b0;
  logic [1:0] actions;

  action_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .DAS_FRAMES(DAS),
    .ARR_FRAMES(ARR)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .buttons_raw(buttons_raw),
    .vsync(vsync),
    .actions(actions)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    int         c;
    logic [1:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // Reference model state: sync pipeline, debounce run length, press session.
  bit s1[2], s2[2], lvl[2], sess[2], awt[2], strt[2], pend[2];
  int run[2], fr[2];
  bit vs_prev;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clock);
      ph = (ph + 1) % VPER;
      vsync = (ph < 5);
    end
  end

  // Reference model: evaluated on every clock edge with the inputs of that edge.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      if (!reset_n) begin
        for (int i = 0; i < 2; i++) begin
          s1[i] = 0; s2[i] = 0; lvl[i] = 0; sess[i] = 0; awt[i] = 0;
          strt[i] = 0; pend[i] = 0; run[i] = 0; fr[i] = 0;
        end
        vs_prev = 0;
      end else begin
        bit       tick;
        bit [1:0] rise, lvl_pre, act;
        logic [1:0] req;
        tick = vsync && !vs_prev;
        vs_prev = vsync;
        for (int i = 0; i < 2; i++) begin
          lvl_pre[i] = lvl[i];
          rise[i] = 0;
          if (s2[i] != lvl[i]) begin
            run[i]++;
            if (run[i] == D) begin
              lvl[i] = s2[i];
              run[i] = 0;
              rise[i] = lvl[i];
            end
          end else begin
            run[i] = 0;
          end
          s2[i] = s1[i];
          s1[i] = buttons_raw[i];
          act[i] = sess[i] && lvl_pre[i] && !rise[i];
        end
        if (tick) begin
          exp_t e;
          req = 2'b00;
          for (int i = 0; i < 2; i++) begin
            req[i] = pend[i];
`ifdef ACTION_AUTOREPEAT_EN
            if (act[i] && strt[i]) begin
              fr[i]++;
              if (fr[i] == DAS || (fr[i] > DAS && (fr[i] - DAS) % ARR == 0))
                req[i] = 1'b1;
            end
            if (act[i] && awt[i]) begin
              strt[i] = 1;
              fr[i] = 0;
            end
`endif
            if (act[i]) awt[i] = 0;
            pend[i] = 0;
          end
          e.c = cyc;
          e.v = (req == 2'b11) ? 2'b00 : req;
          exp_q.push_back(e);
        end
        for (int i = 0; i < 2; i++) begin
          if (rise[i]) begin
            sess[i] = 1; awt[i] = 1; strt[i] = 0; pend[i] = 1;
          end else if (sess[i] && !lvl_pre[i]) begin
            sess[i] = 0; awt[i] = 0; strt[i] = 0;
          end
        end
      end
    end
  end

  // Monitor: one transaction per tick, plus any stray pulse between ticks.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n) begin
        n_cmp++;
        if (actions !== 2'b00) begin
          n_bad++;
          $display("FAIL reset_actions cyc=%0d got=%b want=00", cyc, actions);
        end
      end else if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (actions !== e.v) begin
          n_bad++;
          $display("FAIL tick_actions cyc=%0d got=%b want=%b", cyc, actions, e.v);
        end else begin
          $display("tick cyc=%0d actions=%b", cyc, actions);
        end
      end else if (actions !== 2'b00) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_pulse cyc=%0d got=%b want=00", cyc, actions);
      end
    end
  end

  task automatic hold(input logic [1:0] b, input int n);
    buttons_raw = b;
    repeat (n) @(negedge clock);
  endtask

  task automatic bounce(input logic [1:0] b, input int period, input int n);
    for (int k = 0; k < n; k++) begin
      buttons_raw = (k % 2 == 0) ? b : 2'b00;
      repeat (period) @(negedge clock);
    end
  endtask

  task automatic wait_frame_start();
    int guard;
    guard = 0;
    while (vsync !== 1'b0 && guard < 2 * VPER) begin @(negedge clock); guard++; end
    while (vsync !== 1'b1 && guard < 2 * VPER) begin @(negedge clock); guard++; end
  endtask

  initial begin
    // Reset with both buttons held, then released reset while still held.
    repeat (10) @(negedge clock);
    reset_n = 1'b1;
    hold(2'b11, 3 * VPER);
    hold(2'b00, 2 * VPER);
    // Single press held for ten frames.
    hold(2'b01, 10 * VPER);
    hold(2'b00, 2 * VPER);
    // Bounce shorter than the debounce window.
    bounce(2'b01, 3, 10);
    hold(2'b00, 5 * VPER);
    // Long hold of left.
    hold(2'b10, 10 * VPER + 20);
    hold(2'b00, 2 * VPER);
    // Opposing presses, then left released.
    hold(2'b11, 4 * VPER);
    hold(2'b01, 6 * VPER);
    hold(2'b00, 2 * VPER);
    // Reset while a right move is pending.
    wait_frame_start();
    hold(2'b01, D + 6);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    hold(2'b01, 4 * VPER);
    hold(2'b00, 2 * VPER);
    // Randomized segments.
    for (int s = 0; s < 40; s++) begin
      logic [1:0] b;
      int         n;
      b = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 160);
      if ($urandom_range(0, 3) == 0) begin
        bounce(b, $urandom_range(1, 6), $urandom_range(2, 12));
      end else begin
        hold(b, n);
      end
      if ($urandom_range(0, 15) == 0) begin
        reset_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clock);
        reset_n = 1'b1;
      end
    end
    hold(2'b00, 3 * VPER);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d leftover want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
